// File: rtl/hi_enio_tx.sv
// rtl/hi_enio_tx.sv - ENIO SSP return path: SSP master receive into byte FIFO, replay on mod_out
module hi_enio_tx #(
    parameter int SSP_DIV    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                          ck_1356meg_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [7:0]                    divisor_i,
    output logic                          ssp_clk_o,
    output logic                          ssp_frame_o,
    input  logic                          ssp_dout_i,
    output logic                          mod_out_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          underrun_o
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int DVW = (SSP_DIV > 2) ? $clog2(SSP_DIV) : 1;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    logic           flush;
    logic [DVW-1:0] div_q;
    logic           sclk_q, frame_q, slot_valid_q, enable_q;
    logic [2:0]     rx_bit_q;
    logic [6:0]     rx_sr_q;
    logic           tick, rise, fall, full, push, pop;
    logic [7:0]     push_data, fifo_rd;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;

    state_t         state_q, state_d;
    logic [6:0]     tx_sr_q, tx_sr_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     bit_tmr_q, bit_tmr_d;
    logic           mod_q, mod_d, underrun_set, underrun_q;

    // Disabled behaves as reset for everything except the sticky underrun flag.
    assign flush     = rst_i | ~enable_i;
    assign tick      = (div_q == DVW'(SSP_DIV - 1));
    assign rise      = tick & ~sclk_q;
    assign fall      = tick & sclk_q;
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign push      = rise & (rx_bit_q == 3'd7) & slot_valid_q;
    assign push_data = {rx_sr_q, ssp_dout_i};
    assign fifo_rd   = mem[rd_ptr_q];

    always_ff @(posedge ck_1356meg_i) begin
        if (flush) begin
            div_q        <= '0;
            sclk_q       <= 1'b0;
            frame_q      <= 1'b0;
            slot_valid_q <= 1'b0;
            rx_bit_q     <= 3'd0;
            rx_sr_q      <= 7'd0;
        end else begin
            div_q <= tick ? '0 : div_q + DVW'(1);
            if (tick)
                sclk_q <= ~sclk_q;
            if (rise) begin
                rx_sr_q  <= {rx_sr_q[5:0], ssp_dout_i};
                rx_bit_q <= rx_bit_q + 3'd1;
            end
            // Slot is offered only if the whole byte is guaranteed to fit.
            if (fall) begin
                if (rx_bit_q == 3'd0) begin
                    frame_q      <= ~full;
                    slot_valid_q <= ~full;
                end else begin
                    frame_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ck_1356meg_i) begin
        if (push)
            mem[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge ck_1356meg_i) begin
        if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        tx_sr_d      = tx_sr_q;
        bit_cnt_d    = bit_cnt_q;
        bit_tmr_d    = bit_tmr_q;
        mod_d        = mod_q;
        underrun_set = 1'b0;
        pop          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mod_d = IDLE_LEVEL;
                if (count_q != '0) begin
                    pop       = 1'b1;
                    tx_sr_d   = fifo_rd[6:0];
                    mod_d     = fifo_rd[7];
                    bit_cnt_d = 3'd0;
                    bit_tmr_d = divisor_i;
                    state_d   = ST_SHIFT;
                end
            end
            default: begin
                if (bit_tmr_q != 8'd0) begin
                    bit_tmr_d = bit_tmr_q - 8'd1;
                end else if (bit_cnt_q != 3'd7) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    mod_d     = tx_sr_q[6];
                    tx_sr_d   = {tx_sr_q[5:0], 1'b0};
                    bit_tmr_d = divisor_i;
                end else if (count_q != '0) begin
                    pop       = 1'b1;
                    tx_sr_d   = fifo_rd[6:0];
                    mod_d     = fifo_rd[7];
                    bit_cnt_d = 3'd0;
                    bit_tmr_d = divisor_i;
                end else begin
                    mod_d        = IDLE_LEVEL;
                    underrun_set = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge ck_1356meg_i) begin
        if (flush) begin
            state_q   <= ST_IDLE;
            tx_sr_q   <= 7'd0;
            bit_cnt_q <= 3'd0;
            bit_tmr_q <= 8'd0;
            mod_q     <= IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            bit_cnt_q <= bit_cnt_d;
            bit_tmr_q <= bit_tmr_d;
            mod_q     <= mod_d;
        end
    end

    always_ff @(posedge ck_1356meg_i) begin
        enable_q <= rst_i ? 1'b0 : enable_i;
        if (rst_i || (enable_i && !enable_q))
            underrun_q <= 1'b0;
        else if (!flush && underrun_set)
            underrun_q <= 1'b1;
    end

    assign ssp_clk_o    = sclk_q;
    assign ssp_frame_o  = frame_q;
    assign mod_out_o    = mod_q;
    assign fifo_count_o = count_q;
    assign underrun_o   = underrun_q;
endmodule

// File: tb/tb_hi_enio_tx.sv
// tb/tb_hi_enio_tx.sv - scoreboard bench for hi_enio_tx with a behavioural ARM SSP slave
module tb_hi_enio_tx;
    logic       clk = 1'b0;
    logic       rst, enable, ssp_dout;
    logic [7:0] divisor;
    logic       ssp_clk, ssp_frame, mod_out, underrun;
    logic [4:0] fifo_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] arm_q[$];
    logic [7:0] exp_q[$];
    bit         arm_active = 0;
    int         arm_bitpos = 0;
    logic [7:0] arm_cur    = 8'h00;
    int         max_cnt    = 0;

    hi_enio_tx dut (
        .ck_1356meg_i (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .divisor_i    (divisor),
        .ssp_clk_o    (ssp_clk),
        .ssp_frame_o  (ssp_frame),
        .ssp_dout_i   (ssp_dout),
        .mod_out_o    (mod_out),
        .fifo_count_o (fifo_count),
        .underrun_o   (underrun)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ARM side: shifts a byte out MSB first on ssp_clk falls, starting on the framed fall.
    initial begin : arm_model
        logic prev_sclk, prev_frame;
        int   prev_count;
        prev_sclk  = 1'b0;
        prev_frame = 1'b0;
        prev_count = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !enable) begin
                arm_active = 0;
                ssp_dout   = 1'b0;
                exp_q.delete();
            end else begin
                if (ssp_frame && !prev_frame)
                    check("frame_room", prev_count < 16, 1);
                if (prev_sclk && !ssp_clk) begin
                    if (ssp_frame) begin
                        arm_cur    = (arm_q.size() > 0) ? arm_q.pop_front() : 8'h00;
                        exp_q.push_back(arm_cur);
                        arm_bitpos = 7;
                        arm_active = 1;
                        ssp_dout   = arm_cur[7];
                    end else if (arm_active) begin
                        if (arm_bitpos == 0) begin
                            arm_active = 0;
                            ssp_dout   = 1'b0;
                        end else begin
                            arm_bitpos--;
                            ssp_dout = arm_cur[arm_bitpos];
                        end
                    end
                end
            end
            if (int'(fifo_count) > max_cnt)
                max_cnt = int'(fifo_count);
            prev_sclk  = ssp_clk;
            prev_frame = ssp_frame;
            prev_count = int'(fifo_count);
        end
    end

    task automatic do_reset();
        arm_q.delete();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_nonzero(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (fifo_count != 5'd0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_mod_high(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (mod_out === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Checks every clock of n scoreboard bytes; entered on the negedge where the first push is visible.
    task automatic check_stream(input int n, input int div);
        logic [7:0] b;
        for (int j = 0; j < n; j++) begin
            check("sb_avail", exp_q.size() > 0, 1);
            b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            for (int k = 0; k < 8; k++)
                for (int c = 0; c <= div; c++) begin
                    @(negedge clk);
                    check($sformatf("stream b%0d bit%0d clk%0d", j, k, c), mod_out, b[7-k]);
                end
        end
    endtask

    initial begin : main
        bit         ok;
        logic [7:0] b;
        rst      = 1'b1;
        enable   = 1'b1;
        divisor  = 8'd3;
        ssp_dout = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sclk", ssp_clk, 0);
        check("rst_frame", ssp_frame, 0);
        check("rst_mod", mod_out, 0);
        check("rst_count", fifo_count, 0);
        check("rst_underrun", underrun, 0);
        rst = 1'b0;

        // single byte at 4 clocks per bit, then starve
        arm_q.push_back(8'hA5);
        wait_nonzero(500, ok);
        check("t2_push_seen", ok, 1);
        check("t2_count1", fifo_count, 1);
        check("t2_idle_before", mod_out, 0);
        check("t2_no_underrun", underrun, 0);
        check_stream(1, 3);
        @(negedge clk);
        check("t2_idle_after", mod_out, 0);
        check("t2_underrun", underrun, 1);

        // 20 bytes at slowest rate: FIFO fills, frames suppressed, nothing lost
        do_reset();
        divisor = 8'd255;
        max_cnt = 0;
        for (int i = 0; i < 20; i++) arm_q.push_back(8'(i));
        wait_nonzero(500, ok);
        check("t3_push_seen", ok, 1);
        check_stream(20, 255);
        check("t3_max_count", max_cnt, 16);

        // FF,00,FF at one clock per bit, seamless
        do_reset();
        divisor = 8'd255;
        arm_q.push_back(8'h00);
        arm_q.push_back(8'hFF);
        arm_q.push_back(8'h00);
        arm_q.push_back(8'hFF);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (fifo_count >= 5'd3) begin
                ok = 1;
                break;
            end
        end
        check("t4_queued", ok, 1);
        divisor = 8'd0;
        wait_mod_high(3000, ok);
        check("t4_first_one", ok, 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        for (int j = 0; j < 3; j++) begin
            b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            for (int k = 0; k < 8; k++) begin
                check($sformatf("t4 b%0d bit%0d", j, k), mod_out, b[7-k]);
                @(negedge clk);
            end
        end

        // enable dropped mid-byte with bytes queued; underrun is sticky until enable rises
        do_reset();
        divisor = 8'd0;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (underrun === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check("t5_underrun_set", ok, 1);
        divisor = 8'd255;
        arm_q.push_back(8'hC3);
        arm_q.push_back(8'h11);
        arm_q.push_back(8'h22);
        arm_q.push_back(8'h33);
        arm_q.push_back(8'h44);
        wait_mod_high(3000, ok);
        check("t5_c3_start", ok, 1);
        repeat (900) @(negedge clk);
        check("t5_queued4", fifo_count >= 5'd4, 1);
        check("t5_underrun_held", underrun, 1);
        enable = 1'b0;
        @(negedge clk);
        check("t5_mod_idle", mod_out, 0);
        check("t5_count_flush", fifo_count, 0);
        check("t5_underrun_kept", underrun, 1);
        check("t5_sclk", ssp_clk, 0);
        repeat (3) @(negedge clk);
        check("t5_underrun_kept2", underrun, 1);
        enable = 1'b1;
        @(negedge clk);
        check("t5_underrun_clr", underrun, 0);

        // reset in the middle of a received byte
        do_reset();
        divisor = 8'd3;
        arm_q.push_back(8'h99);
        arm_q.push_back(8'h5A);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (arm_active && arm_bitpos == 3) begin
                ok = 1;
                break;
            end
        end
        check("t6_mid_byte", ok, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_count_rst", fifo_count, 0);
        rst = 1'b0;
        wait_nonzero(500, ok);
        check("t6_push_seen", ok, 1);
        check_stream(1, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
